// File: rtl/mem_arb_defs.sv
// Shared definitions for the DRAM port arbiter: FSM states, requester IDs and
// line geometry.
package mem_arb_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  localparam int LINE_OFFSET_BITS = 5;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: on a tie the side that did not win last time gets
// the grant, a lone requester always wins.
module rr_arbiter2
  import mem_arb_defs::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    grant = REQ_I;
    if (req[REQ_I] && req[REQ_D]) begin
      grant = ~last_grant;
    end else if (req[REQ_D]) begin
      grant = REQ_D;
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Shares one DRAM line port between the I-side and D-side cache paths, one
// transaction at a time, with a watchdog that aborts a DRAM that never acks.
module dram_arbiter
  import mem_arb_defs::*;
#(
  parameter int DATA_WIDTH  = 256,
  parameter int ADDR_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_data_o,
  output logic                  i_ack,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_data_i,
  output logic [DATA_WIDTH-1:0] d_data_o,
  output logic                  d_ack,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic                  mem_ack,
  output logic                  err_o
);

  localparam int WD_WIDTH = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit WD_EN    = (TIMEOUT_CYC > 0);
  localparam logic [WD_WIDTH-1:0] WD_LAST =
    (TIMEOUT_CYC > 0) ? WD_WIDTH'(TIMEOUT_CYC - 1) : '0;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~ADDR_WIDTH'((1 << LINE_OFFSET_BITS) - 1);

  state_t                state, state_nxt;
  logic                  last_grant;
  logic                  pick_grant, pick_valid;
  logic                  grant_en, capture_en, abort;
  logic                  lat_we;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_data;
  logic [WD_WIDTH-1:0]   wd_cnt;
  logic                  err_flag;

  rr_arbiter2 u_rr (
    .req        ({d_req, i_req}),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .valid      (pick_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // mem_ack wins over a watchdog expiry landing on the same cycle.
  always_comb begin
    state_nxt  = state;
    grant_en   = 1'b0;
    capture_en = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_en  = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          capture_en = 1'b1;
          state_nxt  = DONE;
        end else if (WD_EN && (wd_cnt == WD_LAST)) begin
          abort     = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // last_grant doubles as the owner of the transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= REQ_D;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_data   <= '0;
      wd_cnt     <= '0;
      err_flag   <= 1'b0;
      i_data_o   <= '0;
      d_data_o   <= '0;
    end else begin
      if (grant_en) begin
        last_grant <= pick_grant;
        wd_cnt     <= '0;
        err_flag   <= 1'b0;
        if (pick_grant == REQ_D) begin
          lat_we   <= d_we;
          lat_addr <= d_addr & LINE_MASK;
          lat_data <= d_data_i;
        end else begin
          lat_we   <= 1'b0;
          lat_addr <= i_addr & LINE_MASK;
          lat_data <= '0;
        end
      end
      if (WD_EN && (state == BUSY)) begin
        wd_cnt <= wd_cnt + WD_WIDTH'(1);
      end
      if (abort) begin
        err_flag <= 1'b1;
      end
      if (capture_en) begin
        if (last_grant == REQ_D) begin
          d_data_o <= mem_data_i;
        end else begin
          i_data_o <= mem_data_i;
        end
      end
    end
  end

  assign mem_cs     = (state == BUSY);
  assign mem_we     = mem_cs & lat_we;
  assign mem_addr   = lat_addr;
  assign mem_data_o = lat_data;
  assign i_ack      = (state == DONE) && (last_grant == REQ_I);
  assign d_ack      = (state == DONE) && (last_grant == REQ_D);
  assign err_o      = (state == DONE) && err_flag;

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: table of transactions with a DRAM model,
// an ack scoreboard, and hand-written reset/idle-ack sequences.
module tb_dram_arbiter;

  localparam int TO = 12;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_req, d_req, d_we, mem_ack;
  logic [31:0]  i_addr, d_addr;
  logic [255:0] d_data_i, mem_data_i;
  logic [255:0] i_data_o, d_data_o, mem_data_o;
  logic         i_ack, d_ack, mem_cs, mem_we, err_o;
  logic [31:0]  mem_addr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         side;
    logic [255:0] data;
    logic         err;
  } exp_t;

  typedef struct {
    logic         i_req;
    logic         d_req;
    logic [31:0]  i_addr;
    logic [31:0]  d_addr;
    logic         d_we;
    logic [255:0] wdata;
    int           lat;
    logic         exp_side;
    logic [31:0]  exp_addr;
    logic         exp_we;
    logic [255:0] exp_wdata;
  } vec_t;

  exp_t         q[$];
  exp_t         mon_e;
  vec_t         vecs[11];
  logic [255:0] i_model, d_model;

  dram_arbiter #(
    .DATA_WIDTH  (256),
    .ADDR_WIDTH  (32),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_data_o   (i_data_o),
    .i_ack      (i_ack),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_data_i   (d_data_i),
    .d_data_o   (d_data_o),
    .d_ack      (d_ack),
    .mem_cs     (mem_cs),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_data_o (mem_data_o),
    .mem_data_i (mem_data_i),
    .mem_ack    (mem_ack),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] randline();
    logic [255:0] r;
    for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic vec_t mk(input logic ir, input logic dr, input logic [31:0] ia,
                              input logic [31:0] da, input logic we, input logic [255:0] wd,
                              input int lat, input logic side, input logic [31:0] ea,
                              input logic ew, input logic [255:0] ewd);
    vec_t v;
    v.i_req = ir; v.d_req = dr; v.i_addr = ia; v.d_addr = da; v.d_we = we;
    v.wdata = wd; v.lat = lat; v.exp_side = side; v.exp_addr = ea;
    v.exp_we = ew; v.exp_wdata = ewd;
    return v;
  endfunction

  // Acks are checked against the scoreboard; any ack with nothing expected is an error.
  always @(negedge clk) begin
    if (rst) begin
      if (i_ack || d_ack) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_ack: got i_ack=%0b d_ack=%0b expected none", i_ack, d_ack);
        end else begin
          mon_e = q.pop_front();
          checkOutput("ack_side", {d_ack, i_ack}, mon_e.side ? 2'b10 : 2'b01);
          checkOutput("ack_data", mon_e.side ? d_data_o : i_data_o, mon_e.data);
          checkOutput("ack_err", err_o, mon_e.err);
        end
      end else if (err_o) begin
        checks++;
        errors++;
        $display("[TB] FAIL stray_err: got err_o=1 expected 0");
      end
    end
  end

  task automatic applyStimulus(input vec_t v);
    logic [255:0] rd;
    exp_t         e;
    int           k;
    bit           seen, stable;
    @(negedge clk);
    i_req = v.i_req; d_req = v.d_req; i_addr = v.i_addr; d_addr = v.d_addr;
    d_we = v.d_we; d_data_i = v.wdata;
    seen = 1'b0;
    for (int t = 0; t < 4 && !seen; t++) begin
      @(negedge clk);
      seen = mem_cs;
    end
    if (!seen) begin
      checkOutput("grant_timeout", 256'(mem_cs), 256'(1));
      i_req = 1'b0; d_req = 1'b0;
      return;
    end
    checkOutput("mem_addr", mem_addr, v.exp_addr);
    checkOutput("mem_we", mem_we, v.exp_we);
    checkOutput("mem_data_o", mem_data_o, v.exp_wdata);
    if (v.lat == 0) begin
      e.side = v.exp_side; e.err = 1'b1;
      e.data = v.exp_side ? d_model : i_model;
      q.push_back(e);
    end
    k = 0;
    stable = 1'b1;
    while (mem_cs && k < TO + 4) begin
      k++;
      if (mem_addr !== v.exp_addr || mem_we !== v.exp_we || mem_data_o !== v.exp_wdata)
        stable = 1'b0;
      if (k == v.lat) begin
        rd = randline();
        mem_data_i = rd;
        mem_ack = 1'b1;
        e.side = v.exp_side; e.err = 1'b0; e.data = rd;
        q.push_back(e);
        if (v.exp_side) d_model = rd; else i_model = rd;
      end
      @(negedge clk);
      mem_ack = 1'b0;
    end
    checkOutput("cs_cycles", 256'(k), 256'((v.lat > 0) ? v.lat : TO));
    checkOutput("mem_stable", 256'(stable), 256'(1));
    if (v.exp_side) d_req = 1'b0; else i_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
    i_addr = '0; d_addr = '0; d_data_i = '0; mem_data_i = '0;
    i_model = '0; d_model = '0;

    vecs[0]  = mk(1, 1, 32'h1000_0123, 32'h2000_0ABC, 1, {8{32'hA5A5_0001}}, 1,  0, 32'h1000_0120, 0, '0);
    vecs[1]  = mk(0, 1, 32'h1000_0123, 32'h2000_0ABC, 1, {8{32'hA5A5_0001}}, 2,  1, 32'h2000_0AA0, 1, {8{32'hA5A5_0001}});
    vecs[2]  = mk(1, 1, 32'h3000_0005, 32'h4000_001F, 0, {8{32'h5A5A_0002}}, 3,  0, 32'h3000_0000, 0, '0);
    vecs[3]  = mk(1, 0, 32'h0000_0047, 32'h4000_001F, 0, {8{32'h5A5A_0002}}, 10, 0, 32'h0000_0040, 0, '0);
    vecs[4]  = mk(1, 1, 32'h5000_0010, 32'h6000_0033, 1, {8{32'hC3C3_0003}}, 1,  1, 32'h6000_0020, 1, {8{32'hC3C3_0003}});
    vecs[5]  = mk(1, 1, 32'h5000_0010, 32'h6000_0033, 1, {8{32'hC3C3_0003}}, 2,  0, 32'h5000_0000, 0, '0);
    vecs[6]  = mk(1, 1, 32'h7000_00FF, 32'h8000_0040, 0, {8{32'h3C3C_0004}}, 4,  1, 32'h8000_0040, 0, {8{32'h3C3C_0004}});
    vecs[7]  = mk(1, 1, 32'h7000_00FF, 32'h8000_0040, 0, {8{32'h3C3C_0004}}, 1,  0, 32'h7000_00E0, 0, '0);
    vecs[8]  = mk(0, 1, 32'h7000_00FF, 32'h9000_0101, 0, {8{32'h1111_0005}}, TO, 1, 32'h9000_0100, 0, {8{32'h1111_0005}});
    vecs[9]  = mk(0, 1, 32'h7000_00FF, 32'hA000_0202, 1, {8{32'h2222_0006}}, 0,  1, 32'hA000_0200, 1, {8{32'h2222_0006}});
    vecs[10] = mk(1, 0, 32'hB000_001F, 32'hA000_0202, 0, '0,                 1,  0, 32'hB000_0000, 0, '0);

    repeat (3) @(negedge clk);
    checkOutput("rst_i_ack", i_ack, 0);
    checkOutput("rst_d_ack", d_ack, 0);
    checkOutput("rst_err", err_o, 0);
    checkOutput("rst_mem_cs", mem_cs, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_data", mem_data_o, 0);
    checkOutput("rst_i_data", i_data_o, 0);
    checkOutput("rst_d_data", d_data_o, 0);
    rst = 1'b1;

    for (int n = 0; n < 10; n++) applyStimulus(vecs[n]);

    // Reset in the middle of a BUSY access, then a late mem_ack while idle.
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'hC000_0044;
    for (int t = 0; t < 4 && !mem_cs; t++) @(negedge clk);
    checkOutput("mid_busy_cs", mem_cs, 1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_rst_cs", mem_cs, 0);
    checkOutput("async_rst_mem_addr", mem_addr, 0);
    checkOutput("async_rst_i_ack", i_ack, 0);
    checkOutput("async_rst_d_data", d_data_o, 0);
    checkOutput("async_rst_i_data", i_data_o, 0);
    i_model = '0; d_model = '0;
    i_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mem_data_i = randline();
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      checkOutput("idle_after_late_ack_cs", mem_cs, 0);
    end
    checkOutput("q_empty_after_reset", 256'(q.size()), 0);

    applyStimulus(vecs[10]);

    repeat (3) @(negedge clk);
    checkOutput("q_empty_final", 256'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
